// File: rtl/fifo_ms_rr_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ms_rr_reader
// Description : Round-robin reader for a multi-stream FIFO. Each cycle a
//               stream is eligible when it is enabled and its FIFO is not
//               empty. Eligible streams are served in round-robin order,
//               starting at the stream after the last one granted. Every
//               granted word is popped with a one-cycle rd strobe, captured
//               on the following cycle, and presented downstream with its
//               stream index until it is accepted.
//
// Ports       : ck        - clock; all state changes on its rising edge
//               rst       - asynchronous, active-low reset
//               empty     - per-stream empty flags from the FIFO   [FLUX]
//               fifo_data - FIFO read data, valid the cycle after rd [WIDTH]
//               en        - per-stream service enable mask         [FLUX]
//               rd        - one-hot read strobe to the FIFO        [FLUX]
//               out_data  - registered word presented downstream   [WIDTH]
//               out_tag   - index of the stream out_data came from [TAG_WIDTH]
//               out_valid - out_data/out_tag valid
//               out_ready - downstream accepts on out_valid & out_ready
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ms_rr_reader #(
    parameter int WIDTH = 8,
    parameter int FLUX  = 2,
    localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic [FLUX-1:0]      empty,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic [FLUX-1:0]      en,
    output logic [FLUX-1:0]      rd,
    output logic [WIDTH-1:0]     out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // State encoding
    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_cap   = 2'd1;
    localparam logic [1:0] c_valid = 2'd2;

    // Reset value of the last grant: the first search then starts at stream 0
    localparam logic [TAG_WIDTH-1:0] c_last_init = TAG_WIDTH'(FLUX - 1);

    logic [1:0]           r_state;
    logic [TAG_WIDTH-1:0] r_last;       // last granted stream; also tags the word in flight
    logic [WIDTH-1:0]     r_out_data;
    logic [TAG_WIDTH-1:0] r_out_tag;
    logic                 r_out_valid;

    logic [FLUX-1:0]      w_elig;
    logic                 w_any;
    logic [TAG_WIDTH-1:0] w_sel;
    logic                 w_issue;
    int                   w_dist;
    int                   w_best;

    assign w_elig = en & ~empty;

    // Round-robin pick: every eligible stream is ranked by its distance from
    // the stream following the last grant (wrapping); the smallest distance
    // wins. This avoids any variable-index select on the request vector.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_dist = 0;
        w_best = 0;
        for (int i = 0; i < FLUX; i++) begin
            w_dist = (i + FLUX - 1 - int'(r_last)) % FLUX;
            if (w_elig[i] && (!w_any || (w_dist < w_best))) begin
                w_any  = 1'b1;
                w_best = w_dist;
                w_sel  = TAG_WIDTH'(i);
            end
        end
    end

    // A read is issued from IDLE, or from VALID in the same cycle the held
    // word is accepted (back-to-back). The strobe is forced low while reset
    // is asserted, since the state register is being held in IDLE.
    assign w_issue = rst && w_any &&
                     ((r_state == c_idle) || ((r_state == c_valid) && out_ready));

    always_comb begin
        rd = '0;
        for (int i = 0; i < FLUX; i++) begin
            rd[i] = w_issue && (w_sel == TAG_WIDTH'(i));
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            r_state     <= c_idle;
            r_last      <= c_last_init;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_issue) begin
                        r_last  <= w_sel;
                        r_state <= c_cap;
                    end
                end
                c_cap: begin
                    // FIFO data belongs to the stream granted on the previous cycle
                    r_out_data  <= fifo_data;
                    r_out_tag   <= r_last;
                    r_out_valid <= 1'b1;
                    r_state     <= c_valid;
                end
                c_valid: begin
                    // Word and tag are only ever reloaded in CAP, so they hold
                    // here regardless of en/empty activity.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_issue) begin
                            r_last  <= w_sel;
                            r_state <= c_cap;
                        end else begin
                            r_state <= c_idle;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= c_idle;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ms_rr_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ms_rr_reader
// Description : Self-checking bench for fifo_ms_rr_reader (WIDTH=8, FLUX=2).
//               A queue-based FIFO model feeds the reader; a transaction-level
//               model predicts grants, valid timing and delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ms_rr_reader;

    localparam int WIDTH = 8;
    localparam int FLUX  = 2;

    logic             ck = 1'b0;
    logic             rst = 1'b0;
    logic [FLUX-1:0]  empty = '0;
    logic [WIDTH-1:0] fifo_data = '0;
    logic [FLUX-1:0]  en = '0;
    logic [FLUX-1:0]  rd;
    logic [WIDTH-1:0] out_data;
    logic [0:0]       out_tag;
    logic             out_valid;
    logic             out_ready = 1'b0;

    always #5 ck = ~ck;

    fifo_ms_rr_reader #(.WIDTH(WIDTH), .FLUX(FLUX)) dut (
        .ck        (ck),
        .rst       (rst),
        .empty     (empty),
        .fifo_data (fifo_data),
        .en        (en),
        .rd        (rd),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int checks = 0;
    int errors = 0;

    // FIFO contents per stream
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [6:0] seq0 = 7'h01;
    logic [6:0] seq1 = 7'h01;

    // Transaction-level model
    bit         busy = 1'b0;   // a word has been popped and not yet accepted
    int         age = 0;       // edges since the pop
    logic       m_last = 1'b1;
    logic [7:0] pend_data = '0;
    logic       pend_tag = 1'b0;
    int         hs_count = 0;

    // Samples from the latest cycle
    logic [1:0] s_rd;
    logic       s_valid;
    logic       s_tag;
    logic [7:0] s_data;

    typedef struct {
        bit         rst_first;
        logic [1:0] fmask;
        logic [1:0] en;
        logic       rdy;
        logic [1:0] rd;
        logic       valid;
        logic       tag;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Words carry their stream index in the MSB
    task automatic push_words(input int s, input int n);
        for (int j = 0; j < n; j++) begin
            if (s == 0) begin
                q0.push_back({1'b0, seq0});
                seq0 = seq0 + 7'd1;
            end else begin
                q1.push_back({1'b1, seq1});
                seq1 = seq1 + 7'd1;
            end
        end
    endtask

    task automatic clear_fifo();
        q0.delete();
        q1.delete();
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic run_cycle(input logic [1:0] fmask, input logic [1:0] en_v, input logic rdy);
        logic [1:0] elig;
        logic [1:0] exp_rd;
        logic       exp_any;
        logic       exp_issue;
        logic       exp_valid;
        logic       sel;
        int         idx;
        en        = en_v;
        out_ready = rdy;
        empty     = fmask | {q1.size() == 0, q0.size() == 0};
        #3;
        s_rd    = rd;
        s_valid = out_valid;
        s_tag   = out_tag[0];
        s_data  = out_data;

        elig      = en_v & ~empty;
        exp_valid = busy && (age >= 1);
        exp_any   = 1'b0;
        sel       = 1'b0;
        for (int k = 1; k <= FLUX; k++) begin
            idx = (int'(m_last) + k) % FLUX;
            if (!exp_any && (((elig >> idx) & 2'b01) != 2'b00)) begin
                exp_any = 1'b1;
                sel     = idx[0];
            end
        end
        exp_issue = exp_any && (!busy || (exp_valid && rdy));
        exp_rd    = exp_issue ? (2'b01 << sel) : 2'b00;

        check("rd", s_rd, exp_rd);
        check("out_valid", s_valid, exp_valid);
        if (exp_valid) begin
            check("out_tag", s_tag, pend_tag);
            check("out_data", s_data, pend_data);
        end

        if (busy) age++;
        if (exp_valid && rdy) begin
            busy = 1'b0;
            hs_count++;
        end
        if (exp_issue) begin
            busy     = 1'b1;
            age      = 0;
            m_last   = sel;
            pend_tag = sel;
            if (sel) pend_data = q1.pop_front();
            else     pend_data = q0.pop_front();
        end

        @(posedge ck);
        #1;
        // Only the cycle after a pop carries meaningful FIFO data
        if (exp_issue) fifo_data = pend_data;
        else           fifo_data = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        check("rst_rd", rd, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        @(posedge ck);
        #1;
        rst    = 1'b1;
        busy   = 1'b0;
        age    = 0;
        m_last = 1'b1;
    endtask

    initial begin
        // Directed vectors: alternating service, then single-stream service
        tbl[0]  = '{1'b1, 2'b00, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b00, 2'b11, 1'b1, 2'b10, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'b00, 2'b11, 1'b1, 2'b10, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'b00, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 2'b10, 2'b11, 1'b1, 2'b01, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'b10, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'b10, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 2'b10, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'b10, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst_first) begin
                do_reset();
                clear_fifo();
                push_words(0, 8);
                push_words(1, 8);
            end
            run_cycle(tbl[i].fmask, tbl[i].en, tbl[i].rdy);
            check("vec_rd", s_rd, tbl[i].rd);
            check("vec_valid", s_valid, tbl[i].valid);
            if (tbl[i].valid) check("vec_tag", s_tag, tbl[i].tag);
        end

        // Backpressure: A5 held for five cycles with out_ready low
        do_reset();
        clear_fifo();
        q0.push_back(8'hA5);
        push_words(1, 2);
        run_cycle(2'b10, 2'b11, 1'b0);
        run_cycle(2'b10, 2'b11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_cycle(2'b00, 2'b11, 1'b0);
            check("hold_data", s_data, 8'hA5);
            check("hold_rd", s_rd, 0);
            check("hold_valid", s_valid, 1);
        end
        run_cycle(2'b00, 2'b11, 1'b1);
        check("release_rd", s_rd, 2'b10);

        // Stream 1 disabled; empty[0] toggled while a word is held
        do_reset();
        clear_fifo();
        push_words(0, 12);
        push_words(1, 12);
        for (int i = 0; i < 24; i++) begin
            run_cycle({1'b0, (i % 3) == 2}, 2'b01, 1'($urandom_range(0, 1)));
            check("en_mask_rd1", s_rd[1], 0);
        end

        // Reset during CAP discards the word; next grant goes to stream 0
        do_reset();
        clear_fifo();
        push_words(0, 6);
        push_words(1, 6);
        run_cycle(2'b00, 2'b11, 1'b1);
        run_cycle(2'b00, 2'b11, 1'b1);
        run_cycle(2'b00, 2'b11, 1'b1);
        do_reset();
        run_cycle(2'b00, 2'b00, 1'b1);
        check("post_rst_idle_rd", s_rd, 0);
        run_cycle(2'b00, 2'b11, 1'b1);
        check("post_rst_grant", s_rd, 2'b01);

        // Closed loop: four words per stream drained in full
        do_reset();
        clear_fifo();
        push_words(0, 4);
        push_words(1, 4);
        hs_count = 0;
        for (int i = 0; i < 60 && hs_count < 8; i++) begin
            run_cycle(2'b00, 2'b11, 1'b1);
            if (s_valid) check("tag_msb", s_tag, s_data[7]);
        end
        check("drain_count", hs_count, 8);

        // Randomized traffic with occasional resets
        do_reset();
        clear_fifo();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                if (q0.size() < 3 && $urandom_range(0, 1) == 1) push_words(0, $urandom_range(1, 4));
                if (q1.size() < 3 && $urandom_range(0, 1) == 1) push_words(1, $urandom_range(1, 4));
                run_cycle(($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 3) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_ms_rr_reader.md
FIFO_MS_RR_READER -- requirements
Module: fifo_ms_rr_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width (equal to the multi-stream FIFO word width).
REQ-002 The block SHALL have parameter FLUX, default 2, meaning the number of streams served; TAG_WIDTH = max(1, $clog2(FLUX)).
REQ-003 Port: ck  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: empty  input  FLUX  per-stream empty flags from the multi-stream FIFO.
REQ-006 Port: fifo_data  input  WIDTH  FIFO read data, valid the cycle after rd pulses.
REQ-007 Port: en  input  FLUX  per-stream service enable mask.
REQ-008 Port: rd  output  FLUX  one-hot read strobe to the FIFO.
REQ-009 Port: out_data  output  WIDTH  registered word presented downstream.
REQ-010 Port: out_tag  output  TAG_WIDTH  index of the stream out_data came from.
REQ-011 Port: out_valid  output  1  out_data/out_tag valid.
REQ-012 Port: out_ready  input  1  downstream accepts when out_valid & out_ready at a rising edge.

Function
REQ-013 Stream i SHALL be eligible in a cycle iff en[i]==1 and empty[i]==0 in that cycle.
REQ-014 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod FLUX, wraps, and selects the first eligible stream.
REQ-015 last_grant SHALL update to the selected index only in a cycle where rd is asserted.
REQ-016 rd SHALL be at most one-hot, SHALL be asserted for exactly one cycle per grant, and SHALL never be asserted for a non-eligible stream.
REQ-017 The FSM SHALL have states IDLE, CAP, VALID.
REQ-018 IDLE: out_valid=0; if any stream eligible, assert rd[sel] this cycle and go to CAP; else stay.
REQ-019 CAP: rd=0; at the edge load out_data<=fifo_data, out_tag<=grant index; go to VALID.
REQ-020 VALID: out_valid=1; out_data/out_tag SHALL hold stable while out_ready==0.
REQ-021 VALID with out_ready==1: if any stream eligible, assert rd[sel] the same cycle and go to CAP (back-to-back); else go to IDLE.
REQ-022 Latency SHALL be 2 cycles from rd pulse to out_valid high; peak throughput SHALL be one word per 2 cycles.
REQ-023 Changes to en or empty while in CAP or VALID SHALL NOT affect the held word.
REQ-024 With FLUX==1 the block SHALL reduce to a single-stream reader with out_tag constant 0.

Reset
REQ-025 While rst==0: state=IDLE, rd=0, out_valid=0, out_data=0, out_tag=0, last_grant=FLUX-1 (first search starts at stream 0).
REQ-026 Reset asserted in CAP or VALID SHALL discard the in-flight word (already popped from the FIFO); no rd SHALL be issued in the first cycle after release unless a stream is eligible in that cycle.

Verification
REQ-027 After reset, empty=2'b00, en=2'b11, out_ready=1 -> rd sequence 01,10,01,10 in alternate cycles; out_tag 0,1,0,1.
REQ-028 empty=2'b10 (only stream 0 has data), en=2'b11 -> rd only ever 2'b01; out_tag always 0.
REQ-029 out_ready=0 held 5 cycles in VALID with out_data=8'hA5 -> out_data stays 8'hA5, rd stays 0, no state change.
REQ-030 en=2'b01 with both streams non-empty -> stream 1 never read; clearing empty[0] mid-VALID does not alter out_data.
REQ-031 rst pulsed low during CAP -> next cycle out_valid=0, out_data=0, state IDLE, next grant goes to stream 0.
REQ-032 Closed loop with the multi-stream FIFO (WIDTH=8, FLUX=2, DEPTH=4): write 4 tagged words per stream, drain -> 8 words out, per-stream order preserved, each out_tag matches the datain tag MSB.
